// File: rtl/apb_i2c_fifo_if.sv
// Bus bundle between a FIFO user (master) and apb_i2c_fifo (slave).
// DWIDTH/AWIDTH must match the FIFO instance it connects to.
interface apb_i2c_fifo_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic              WR_ENA;
  logic [DWIDTH-1:0] WRITE_DATA;
  logic              RD_ENA;
  logic              CLR_ERR;
  logic [DWIDTH-1:0] READ_DATA;
  logic              EMPTY;
  logic              FULL;
  logic [AWIDTH:0]   COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic              ALMOST_FULL;
  logic              ALMOST_EMPTY;

  modport master (
    output WR_ENA, WRITE_DATA, RD_ENA, CLR_ERR,
    input  READ_DATA, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW,
           ALMOST_FULL, ALMOST_EMPTY
  );

  modport slave (
    input  WR_ENA, WRITE_DATA, RD_ENA, CLR_ERR,
    output READ_DATA, EMPTY, FULL, COUNT, OVERFLOW, UNDERFLOW,
           ALMOST_FULL, ALMOST_EMPTY
  );
endinterface

// File: rtl/apb_i2c_fifo.sv
// First-word-fall-through FIFO for the APB<->I2C TX/RX paths, with sticky overflow/underflow.
// Optional registered almost-full/almost-empty flags enabled by APB_I2C_FIFO_THRESH_EN.
module apb_i2c_fifo #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_i2c_fifo_if.slave  bus
);
  localparam int              DEPTH   = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = {1'b1, {AWIDTH{1'b0}}};

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = bus.RD_ENA && !empty;
  // A pop at full frees the slot the simultaneous push lands in.
  assign push  = bus.WR_ENA && (!full || bus.RD_ENA);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AWIDTH'(push);
    rd_ptr_d = rd_ptr_q + AWIDTH'(pop);
    count_d  = count_q + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);
    ovf_d    = (bus.WR_ENA && full && !bus.RD_ENA) || (ovf_q && !bus.CLR_ERR);
    unf_d    = (bus.RD_ENA && empty) || (unf_q && !bus.CLR_ERR);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET && push) begin
      mem_q[wr_ptr_q] <= bus.WRITE_DATA;
    end
  end

  assign bus.READ_DATA = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.EMPTY     = empty;
  assign bus.FULL      = full;
  assign bus.COUNT     = count_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = unf_q;

`ifdef APB_I2C_FIFO_THRESH_EN
  localparam logic [AWIDTH:0] AF_C = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_C = (AWIDTH+1)'(AE_LEVEL);

  logic af_q, ae_q;

  // Thresholds follow count_d so they change on the same edge as COUNT.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_d >= AF_C);
      ae_q <= (count_d <= AE_C);
    end
  end

  assign bus.ALMOST_FULL  = af_q;
  assign bus.ALMOST_EMPTY = ae_q;
`else
  assign bus.ALMOST_FULL  = 1'b0;
  assign bus.ALMOST_EMPTY = 1'b0;
`endif
endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Directed plus randomized bench for apb_i2c_fifo against a queue-based reference model.
module tb_apb_i2c_fifo;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic PCLK = 1'b0;
  logic PRESET = 1'b0;

  apb_i2c_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  apb_i2c_fifo #(.DWIDTH(DW), .AWIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [DW-1:0] head;
    bit af_e, ae_e;
    head = (mq.size() != 0) ? mq[0] : '0;
`ifdef APB_I2C_FIFO_THRESH_EN
    af_e = (mq.size() >= 12);
    ae_e = (mq.size() <= 4);
`else
    af_e = 1'b0;
    ae_e = 1'b0;
`endif
    chk("count",     64'(bus.COUNT),       64'(mq.size()));
    chk("empty",     64'(bus.EMPTY),       64'(mq.size() == 0));
    chk("full",      64'(bus.FULL),        64'(mq.size() == DEPTH));
    chk("read_data", 64'(bus.READ_DATA),   64'(head));
    chk("overflow",  64'(bus.OVERFLOW),    64'(m_ovf));
    chk("underflow", 64'(bus.UNDERFLOW),   64'(m_unf));
    chk("alm_full",  64'(bus.ALMOST_FULL), 64'(af_e));
    chk("alm_empty", 64'(bus.ALMOST_EMPTY),64'(ae_e));
  endtask

  // Drive one cycle, advance the model from its pre-edge state, check after the edge.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                      input bit clr, input bit rst);
    bit was_full, was_empty;
    bus.WR_ENA     = wr;
    bus.WRITE_DATA = wd;
    bus.RD_ENA     = rd;
    bus.CLR_ERR    = clr;
    PRESET         = rst;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_ovf = (wr && was_full && !rd) || (m_ovf && !clr);
      m_unf = (rd && was_empty) || (m_unf && !clr);
      if (rd && !was_empty) void'(mq.pop_front());
      if (wr && (!was_full || rd)) mq.push_back(wd);
    end
    @(posedge PCLK);
    #1;
    check_all();
  endtask

  task automatic push(input logic [DW-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();  step(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle(); step(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
  task automatic clr();  step(1'b0, '0, 1'b0, 1'b1, 1'b0); endtask
  task automatic rst();  step(1'b0, '0, 1'b0, 1'b0, 1'b1); endtask

  initial begin
    bus.WR_ENA     = 1'b0;
    bus.WRITE_DATA = '0;
    bus.RD_ENA     = 1'b0;
    bus.CLR_ERR    = 1'b0;
    @(negedge PCLK);

    // Reset state and idle
    rst();
    idle();
    chk("reset_count", 64'(bus.COUNT), 64'd0);
    chk("reset_rdata", 64'(bus.READ_DATA), 64'h0);

    // Single word fall-through
    push(32'hA5A5_0001);
    chk("fwft_data", 64'(bus.READ_DATA), 64'hA5A5_0001);
    chk("fwft_count", 64'(bus.COUNT), 64'd1);
    pop();
    chk("pop_empty", 64'(bus.EMPTY), 64'd1);

    // Fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) push(DW'(i));
    chk("fill_full", 64'(bus.FULL), 64'd1);
    push(32'h0000_DEAD);
    chk("ovf_set", 64'(bus.OVERFLOW), 64'd1);
    chk("ovf_count", 64'(bus.COUNT), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(bus.READ_DATA), 64'(i));
      pop();
    end
    chk("drain_empty", 64'(bus.EMPTY), 64'd1);
    clr();
    chk("ovf_clear", 64'(bus.OVERFLOW), 64'd0);

    // Simultaneous push/pop at full
    for (int i = 0; i < DEPTH; i++) push(DW'(i));
    step(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    chk("full_rw_count", 64'(bus.COUNT), 64'd16);
    chk("full_rw_ovf", 64'(bus.OVERFLOW), 64'd0);
    chk("full_rw_head", 64'(bus.READ_DATA), 64'd1);
    for (int i = 1; i < DEPTH; i++) pop();
    chk("wrap_last", 64'(bus.READ_DATA), 64'h55);
    pop();

    // Underflow, clear, simultaneous push/pop while empty
    pop();
    chk("unf_set", 64'(bus.UNDERFLOW), 64'd1);
    clr();
    chk("unf_clear", 64'(bus.UNDERFLOW), 64'd0);
    step(1'b1, 32'h1234, 1'b1, 1'b1, 1'b0);
    chk("empty_rw_unf", 64'(bus.UNDERFLOW), 64'd1);
    chk("empty_rw_count", 64'(bus.COUNT), 64'd1);
    clr();

    // Reset mid-burst
    for (int i = 0; i < 5; i++) push(32'hB000 + DW'(i));
    rst();
    chk("midrst_count", 64'(bus.COUNT), 64'd0);
    chk("midrst_empty", 64'(bus.EMPTY), 64'd1);
    push(32'h77);
    chk("post_rst_head", 64'(bus.READ_DATA), 64'h77);
    rst();

    // Threshold crossings
    for (int i = 0; i < 4; i++) push(32'hC0 + DW'(i));
`ifdef APB_I2C_FIFO_THRESH_EN
    chk("ae_at4", 64'(bus.ALMOST_EMPTY), 64'd1);
`endif
    push(32'hC4);
`ifdef APB_I2C_FIFO_THRESH_EN
    chk("ae_at5", 64'(bus.ALMOST_EMPTY), 64'd0);
`endif
    for (int i = 5; i < 12; i++) push(32'hC0 + DW'(i));
`ifdef APB_I2C_FIFO_THRESH_EN
    chk("af_at12", 64'(bus.ALMOST_FULL), 64'd1);
`endif
    pop();
`ifdef APB_I2C_FIFO_THRESH_EN
    chk("af_at11", 64'(bus.ALMOST_FULL), 64'd0);
`endif
    rst();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
           $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
